// File: rtl/gsim_matvec_pkg.sv
// gsim_pkg: shared constants and types for the GSIM forward model (b = A*x).
// Holds the frame geometry, the fixed-point formats, the banded matrix
// coefficients and the LOAD/RUN state encoding used by gsim_matvec.
package gsim_pkg;

  localparam int N    = 16;   // vector length (frame size)
  localparam int XW   = 32;   // x element width, signed Q16.16
  localparam int BW   = 16;   // b element width, signed integer
  localparam int FRAC = 16;   // fractional bits of x and of the accumulator
  localparam int ACCW = 38;   // accumulator width, signed Q22.16
  localparam int IW   = $clog2(N);

  // Band coefficients: diagonal, then distance 1, 2 and 3 from the diagonal.
  localparam int C0 = 20;
  localparam int C1 = -13;
  localparam int C2 = 6;
  localparam int C3 = -1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gsim_matvec_if.sv
// gsim_matvec_if: stream bundle between a GSIM x source and the gsim_matvec
// forward model.
//   in_en/x_in      : x elements into the block, accepted while in_ready=1
//   in_ready        : block is in LOAD and can take an element
//   out_valid/b_out : b elements out, index order 0..15
//   b_sat           : b_out was clamped (qualified by out_valid)
//   done            : one-cycle pulse together with b_15
// master = the side producing x and consuming b; slave = gsim_matvec.
interface gsim_matvec_if;
  import gsim_pkg::*;

  logic          in_en;
  logic [XW-1:0] x_in;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] b_out;
  logic          b_sat;
  logic          done;

  modport master (
    output in_en, x_in,
    input  in_ready, out_valid, b_out, b_sat, done
  );

  modport slave (
    input  in_en, x_in,
    output in_ready, out_valid, b_out, b_sat, done
  );

endinterface

// File: rtl/gsim_matvec_band_mac.sv
// gsim_band_mac: 7-tap dot product of an x window [k-3..k+3] with the band
// coefficients (-1, 6, -13, 20, -13, 6, -1), registered output.
// Ports:
//   clk, reset      : clock, synchronous active-low reset (empties the stage)
//   in_valid/in_last: window is valid / window belongs to the last row
//   win             : seven x operands, edge taps already zeroed by the caller
//   out_valid/out_last/acc : registered result, signed Q22.16
module gsim_band_mac
  import gsim_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [6:0][XW-1:0]     win,
  output logic                   out_valid,
  output logic                   out_last,
  output logic signed [ACCW-1:0] acc
);

  logic signed [ACCW-1:0] ext [7];
  logic signed [ACCW-1:0] s1, s2, s3;
  logic signed [ACCW-1:0] t0, t1, t2;
  logic signed [ACCW-1:0] sum;

  // Symmetric taps are paired first so each coefficient is applied once.
  // Multiplies are shift/add: 20 = 16+4, 13 = 8+4+1, 6 = 4+2, 1 = 1.
  // 60 * 2^31 < 2^37, so nothing here can overflow the 38-bit accumulator.
  always_comb begin
    for (int j = 0; j < 7; j++) begin
      ext[j] = {{(ACCW-XW){win[j][XW-1]}}, win[j]};
    end
    s1  = ext[2] + ext[4];
    s2  = ext[1] + ext[5];
    s3  = ext[0] + ext[6];
    t0  = (ext[3] <<< 4) + (ext[3] <<< 2);
    t1  = (s1 <<< 3) + (s1 <<< 2) + s1;
    t2  = (s2 <<< 2) + (s2 <<< 1);
    sum = t0 - t1 + t2 - s3;
  end

  // Result register; valid/last track the window so the next stage knows
  // which row it is looking at.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_valid & in_last;
      if (in_valid) begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/gsim_matvec.sv
// gsim_matvec: forward model for the GSIM solver. Collects a 16-element x
// frame (signed Q16.16), then streams b = A*x (16-bit signed, rounded half
// up and saturated) one element per cycle through a two-stage pipeline.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low; discards any frame in progress
//   bus   : gsim_matvec_if.slave stream (in_en/x_in/in_ready in,
//           out_valid/b_out/b_sat/done out)
module gsim_matvec
  import gsim_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  gsim_matvec_if.slave  bus
);

  localparam logic [IW:0]   LAST_PHASE = (IW+1)'(N + 1);
  localparam logic signed [ACCW-FRAC-1:0] Q_MAX = (ACCW-FRAC)'(32767);
  localparam logic signed [ACCW-FRAC-1:0] Q_MIN = -(ACCW-FRAC)'(32768);

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW:0]   phase_q, phase_d;
  logic [XW-1:0] buf_q [N];

  logic          accept;
  logic          issue;
  logic          issue_last;
  logic [IW-1:0] k;
  logic [4:0]    tap_pos;
  logic [6:0][XW-1:0] win;

  logic                   mac_valid;
  logic                   mac_last;
  logic signed [ACCW-1:0] mac_acc;

  logic [ACCW-1:0]               rnd;
  logic signed [ACCW-FRAC-1:0]   q;
  logic [BW-1:0]                 b_d;
  logic                          sat_d;

  logic          out_valid_q;
  logic [BW-1:0] b_out_q;
  logic          b_sat_q;
  logic          done_q;

  assign accept = (state_q == LOAD) && bus.in_en;
  assign k      = phase_q[IW-1:0];

  // State, element counter and run phase. RUN lasts 18 cycles: 16 issue
  // phases plus two to drain the pipeline, so in_ready only returns after
  // b_15 has left the output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic and issue controls for the MAC stage.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IW'(N - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
            phase_d = '0;
          end
        end
      end
      RUN: begin
        issue      = (phase_q < (IW+1)'(N));
        issue_last = (phase_q == (IW+1)'(N - 1));
        phase_d    = phase_q + 1'b1;
        if (phase_q == LAST_PHASE) begin
          state_d = LOAD;
          phase_d = '0;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  // Frame buffer; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      buf_q[cnt_q] <= bus.x_in;
    end
  end

  // Window for row k: tap j reads x[k+j-3]. tap_pos holds k+j, so the
  // tap is in range when 3 <= tap_pos <= 18; otherwise it contributes 0.
  always_comb begin
    tap_pos = '0;
    win     = '0;
    for (int j = 0; j < 7; j++) begin
      tap_pos = {1'b0, k} + 5'(j);
      if (tap_pos >= 5'd3 && tap_pos <= 5'd18) begin
        win[j] = buf_q[IW'(tap_pos - 5'd3)];
      end
    end
  end

  gsim_band_mac u_mac (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_last   (issue_last),
    .win       (win),
    .out_valid (mac_valid),
    .out_last  (mac_last),
    .acc       (mac_acc)
  );

  // Round half up by adding 0.5 LSB and keeping the integer bits (which is
  // the arithmetic shift), then clamp to the 16-bit signed range.
  always_comb begin
    rnd   = mac_acc + ACCW'(32768);
    q     = rnd[ACCW-1:FRAC];
    b_d   = q[BW-1:0];
    sat_d = 1'b0;
    if (q > Q_MAX) begin
      b_d   = 16'h7FFF;
      sat_d = 1'b1;
    end else if (q < Q_MIN) begin
      b_d   = 16'h8000;
      sat_d = 1'b1;
    end
  end

  // Output register stage; done marks the row that came from the last issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      b_out_q     <= '0;
      b_sat_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= mac_valid;
      done_q      <= mac_valid & mac_last;
      b_sat_q     <= mac_valid & sat_d;
      if (mac_valid) begin
        b_out_q <= b_d;
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.b_out     = b_out_q;
  assign bus.b_sat     = b_sat_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_gsim_matvec.sv
// tb_gsim_matvec: directed scoreboard bench for gsim_matvec. Stimulus tasks
// push hand-computed b values into a queue; a monitor on the falling edge
// pops and compares whenever out_valid is high.
module tb_gsim_matvec;
  import gsim_pkg::*;

  typedef logic [XW-1:0] xvec_t [N];
  typedef int            bvec_t [N];
  typedef bit            svec_t [N];
  typedef struct {
    int b;
    bit sat;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q [$];

  always #5 clk = ~clk;

  gsim_matvec_if bus ();

  gsim_matvec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  xvec_t zero_x, ones_x, imp_x, rnd_x, sat_x;
  svec_t no_sat;
  bvec_t zero_b = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  bvec_t ones_b = '{12,-1,5,4,4,4,4,4,4,4,4,4,4,5,-1,12};
  bvec_t imp_b  = '{0,0,-1,6,-13,20,-13,6,-1,0,0,0,0,0,0,0};
  bvec_t rnd_b  = '{10,-6,3,0,0,0,0,0,0,0,0,0,0,0,0,0};
  bvec_t sat_b  = '{32767,-32768,32767,32767,32767,32767,32767,32767,
                    32767,32767,32767,32767,32767,32767,-32768,32767};
  svec_t sat_s  = '{1,0,1,1,1,1,1,1,1,1,1,1,1,1,0,1};

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void pushExpect(input bvec_t b, input svec_t s, input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.b    = b[i];
      e.sat  = s[i];
      e.last = (i == N - 1);
      sb_q.push_back(e);
    end
  endfunction

  // Monitor: any out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("b_out", int'($signed(bus.b_out)), e.b);
        checkOutput("b_sat", int'(bus.b_sat), int'(e.sat));
        checkOutput("done", int'(bus.done), int'(e.last));
      end
    end else if (bus.done === 1'b1) begin
      checkOutput("done_without_valid", 1, 0);
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},  int'(bus.in_ready), 1);
    checkOutput({tag, "_out_valid"}, int'(bus.out_valid), 0);
    checkOutput({tag, "_b_out"},     int'(bus.b_out), 0);
    checkOutput({tag, "_b_sat"},     int'(bus.b_sat), 0);
    checkOutput({tag, "_done"},      int'(bus.done), 0);
  endtask

  // Loads a full frame (inputs change on the falling edge), then checks
  // in_ready drops after the 16th accept and the 2-cycle output latency.
  task automatic applyStimulus(input xvec_t xv, input bit gaps, input bit hold_en);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_en = 1'b0;
          bus.x_in  = $urandom;
          @(negedge clk);
        end
      end
      bus.in_en = 1'b1;
      bus.x_in  = xv[i];
      @(negedge clk);
    end
    bus.in_en = hold_en;
    bus.x_in  = hold_en ? $urandom : '0;
    checkOutput("in_ready_after_E", int'(bus.in_ready), 0);
    checkOutput("out_valid_E", int'(bus.out_valid), 0);
    @(negedge clk);
    if (hold_en) bus.x_in = $urandom;
    checkOutput("out_valid_E1", int'(bus.out_valid), 0);
    @(negedge clk);
    checkOutput("out_valid_E2", int'(bus.out_valid), 1);
  endtask

  // Waits (bounded) for done, then checks in_ready comes back next cycle.
  task automatic waitFrameDone();
    int cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      bus.in_en = 1'b0;
      bus.x_in  = '0;
      checkOutput("in_ready_during_b15", int'(bus.in_ready), 0);
      @(negedge clk);
      checkOutput("in_ready_after_done", int'(bus.in_ready), 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      zero_x[i] = '0;
      ones_x[i] = 32'h0001_0000;
      imp_x[i]  = (i == 5) ? 32'h0001_0000 : '0;
      rnd_x[i]  = (i == 0) ? 32'h0000_8000 : '0;
      sat_x[i]  = 32'h7FFF_FFFF;
      no_sat[i] = 1'b0;
    end

    reset     = 1'b0;
    bus.in_en = 1'b0;
    bus.x_in  = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] frame: all zero");
    pushExpect(zero_b, no_sat, N);
    applyStimulus(zero_x, 1'b0, 1'b0);
    waitFrameDone();

    $display("[TB] frame: all ones");
    pushExpect(ones_b, no_sat, N);
    applyStimulus(ones_x, 1'b0, 1'b0);
    waitFrameDone();

    $display("[TB] frame: impulse at x5");
    pushExpect(imp_b, no_sat, N);
    applyStimulus(imp_x, 1'b0, 1'b0);
    waitFrameDone();

    $display("[TB] frame: rounding");
    pushExpect(rnd_b, no_sat, N);
    applyStimulus(rnd_x, 1'b0, 1'b0);
    waitFrameDone();

    $display("[TB] frame: saturation");
    pushExpect(sat_b, sat_s, N);
    applyStimulus(sat_x, 1'b0, 1'b0);
    waitFrameDone();

    $display("[TB] frame: impulse with in_en gaps");
    pushExpect(imp_b, no_sat, N);
    applyStimulus(imp_x, 1'b1, 1'b0);
    waitFrameDone();

    $display("[TB] frame: ones with in_en held during RUN");
    pushExpect(ones_b, no_sat, N);
    applyStimulus(ones_x, 1'b0, 1'b1);
    waitFrameDone();

    $display("[TB] reset at load element 9");
    for (int i = 0; i < 9; i++) begin
      bus.in_en = 1'b1;
      bus.x_in  = ones_x[i];
      @(negedge clk);
    end
    bus.x_in = ones_x[9];
    reset    = 1'b0;
    @(negedge clk);
    checkResetState("reset_load");
    reset     = 1'b1;
    bus.in_en = 1'b0;
    repeat (20) @(negedge clk);
    pushExpect(imp_b, no_sat, N);
    applyStimulus(imp_x, 1'b0, 1'b0);
    waitFrameDone();

    $display("[TB] reset at output 7");
    pushExpect(ones_b, no_sat, 7);
    applyStimulus(ones_x, 1'b0, 1'b0);
    begin
      int cyc = 0;
      while (sb_q.size() != 0 && cyc < 60) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      checkOutput("partial_outputs_seen", sb_q.size(), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    checkResetState("reset_run");
    reset = 1'b1;
    repeat (25) @(negedge clk);
    pushExpect(ones_b, no_sat, N);
    applyStimulus(ones_x, 1'b0, 1'b0);
    waitFrameDone();

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsim_matvec.md
# gsim_matvec

- Forward model for the GSIM solver: multiplies a 16-element solution vector x by the fixed banded system matrix A and streams back b = A·x.
- Sits on the opposite side of the GSIM b-in / x-out stream. It takes x in the format GSIM produces (signed Q16.16) and returns b in the format GSIM consumes (16-bit signed integer).
- Used for residual checking and closed-loop self-test: GSIM x_out feeds this block, and its output is compared against the original b.

## Interface
- N, 16, vector length (frame size).
- XW, 32, x_in width, signed Q16.16.
- BW, 16, b_out width, signed integer.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- in_en  in  1  x_in valid; accepted only while in_ready=1.
- x_in  in  32  x element, signed Q16.16, index order 0..15.
- in_ready  out  1  high while the block can accept elements.
- out_valid  out  1  b_out/b_sat valid this cycle.
- b_out  out  16  b element, signed integer, index order 0..15.
- b_sat  out  1  b_out was saturated (qualified by out_valid).
- done  out  1  one-cycle pulse coincident with b_15.

## Operation
- Matrix A: diagonal 20; off-diagonals ±1 = -13, ±2 = +6, ±3 = -1; all other entries 0.
- b_i = 20·x_i − 13(x_{i−1}+x_{i+1}) + 6(x_{i−2}+x_{i+2}) − (x_{i−3}+x_{i+3}). Terms with an index outside 0..15 contribute 0; there is no wrap-around.
- Accumulator: full-precision signed, 38 bits, Q22.16. Σ|coef| = 60 < 64, so it cannot overflow.
- Rounding: b_out = (acc + 2^15) >>> 16 (round half up), then saturate to [−32768, 32767]. b_sat=1 when clamping occurred.
- States:
  - LOAD: in_ready=1. Each in_en cycle writes x_in into buf[cnt] and increments cnt. Gaps in in_en are allowed. When the 16th element is accepted (cnt=15 & in_en), go to RUN.
  - RUN: in_ready=0. Index k = 0..15, one b per cycle, through the two-stage pipeline (MAC, then round/saturate). In_en is ignored and x_in is not stored. After b_15 is issued, go to LOAD with cnt=0.
- Reset: active-low. The next rising edge with reset=0 does the following:
  - forces LOAD with cnt=0 and empties the pipeline;
  - drives out_valid=0, b_out=0, b_sat=0, done=0;
  - leaves buffer contents don't-care.
  - A reset mid-frame or mid-RUN discards the frame; no further out_valid until a complete new frame arrives.

## Timing
- Reset values: in_ready=1 (LOAD), out_valid=0, b_out=0, b_sat=0, done=0.
- The 16th accepting edge is E. in_ready is 0 from the cycle after E.
- First out_valid is high after edge E+2 (2-cycle latency). b_0..b_15 appear on 16 consecutive cycles with no bubbles.
- done=1 in the same cycle as b_15.
- in_ready returns to 1 in the cycle after b_15. A new frame may start in that cycle.
- Minimum frame period: 16 load cycles + 18 cycles of turnaround before the next LOAD.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package gsim_pkg holds:
  - N=16, XW=32, BW=16, FRAC=16, ACCW=38;
  - coefficients C0=20, C1=−13, C2=6, C3=−1;
  - the state enum {LOAD, RUN}.
- Sub-module gsim_band_mac:
  - 7-tap dot product with registered output;
  - operands are the x window [k−3..k+3] with zero-masked edges;
  - coefficient multiplies are shift/add only.
- The top level owns the buffer, counters, FSM and round/saturate stage.

## Test plan
- All x = 0 → 16 outputs b=0, b_sat=0, done with b_15, in_ready back to 1 the cycle after.
- All x = 0x00010000 (1.0) → b = 12, −1, 5, 4 (×10, b_3..b_12), 5, −1, 12.
- Impulse x_5 = 0x00010000, others 0 → b_2..b_8 = −1, 6, −13, 20, −13, 6, −1; all other b = 0.
- Rounding: x_0 = 0x00008000, others 0 → b_0=10, b_1=−6 (−6.5 rounded up), b_2=3, b_3=0 (−0.5 rounded up), rest 0.
- Saturation: all x = 0x7FFFFFFF → b_3..b_12 = 32767 with b_sat=1; b_1 = b_14 = −32768 with b_sat=0.
- Control:
  - in_en with random gaps: outputs identical to the gap-free frame.
  - in_en held high during RUN: ignored, no corruption.
  - reset asserted at load element 9 and again at output 7: no further out_valid until a full new frame, and the new frame's results are correct.
